// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared types and constants for the sequential fp divider
package fp_div_pkg;
  typedef enum logic [1:0] {RNE, RTZ, RDN, RUP} rnd_mode_t;
  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, ROUND, DONE} state_t;
  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;
  function automatic logic [63:0] fp_const(input int mant_bits, input int exp_bits, input logic nan);
    logic [63:0] ones_e;
    ones_e = (64'd1 << exp_bits) - 64'd1;
    return nan ? (ones_e << mant_bits) | (64'd1 << (mant_bits - 1))
               : ((ones_e - 64'd1) << mant_bits) | ((64'd1 << mant_bits) - 64'd1);
  endfunction
endpackage

// File: rtl/fp_div_round.sv
// fp_div_round: denormal shift, rounding, overflow saturation, packing and flags
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int BITS = 32,
  parameter int MANTISSA_BITS = 23,
  parameter int EXPONENT_BITS = 8,
  localparam int Q = MANTISSA_BITS + 3,
  localparam int EW = EXPONENT_BITS + 2
) (
  input  logic [Q-1:0]         quot,
  input  logic                 sticky_in,
  input  logic signed [EW-1:0] exp_in,
  input  logic                 sign,
  input  rnd_mode_t            rnd_mode,
  output logic [BITS-1:0]      result,
  output fp_flags_t            flags
);
  localparam int M = MANTISSA_BITS;
  localparam int E = EXPONENT_BITS;
  localparam logic [BITS-1:0] MAXF = BITS'(fp_const(M, E, 1'b0));
  logic tiny, big, g, r, st, inc, to_inf, ovf, inexact;
  logic [EW-1:0] shamt;
  logic [2*Q-1:0] ext;
  logic [Q-1:0] q_sh;
  logic [M+1:0] rm;
  logic signed [EW-1:0] e_adj, e_out;
  assign tiny = exp_in < $signed(EW'(1));
  assign shamt = EW'(1) - exp_in;
  assign big = tiny && shamt > EW'(Q - 1);
  assign ext = {quot, {Q{1'b0}}} >> (tiny ? shamt : '0);
  assign q_sh = big ? '0 : ext[2*Q-1:Q];
  assign st = sticky_in | (big ? |quot : |ext[Q-1:0]);
  assign g = q_sh[1];
  assign r = q_sh[0];
  assign inexact = g | r | st;
  assign inc = rnd_mode == RNE ? g & (r | st | q_sh[2]) :
               rnd_mode == RDN ? sign & inexact :
               rnd_mode == RUP ? !sign & inexact : 1'b0;
  assign rm = {1'b0, q_sh[Q-1:2]} + (M+2)'(inc);
  assign e_adj = tiny ? $signed(EW'(1)) : exp_in;
  assign e_out = rm[M+1] ? e_adj + $signed(EW'(1)) : rm[M] ? e_adj : '0;
  assign ovf = e_out >= $signed(EW'((1 << E) - 1));
  assign to_inf = rnd_mode == RNE || (rnd_mode == RDN && sign) || (rnd_mode == RUP && !sign);
  assign result = !ovf ? {sign, e_out[E-1:0], rm[M-1:0]} :
                  to_inf ? {sign, {E{1'b1}}, {M{1'b0}}} : {sign, MAXF[BITS-2:0]};
  assign flags = '{invalid: 1'b0, div_by_zero: 1'b0, overflow: ovf,
                   underflow: tiny & inexact, inexact: inexact | ovf};
endmodule

// File: rtl/zeroMSBCounter.sv
// zeroMSBCounter: number of zero bits above the most significant set bit
module zeroMSBCounter #(
  parameter int W = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) count = value[i] ? CW'(W - 1 - i) : count;
  end
endmodule

// File: rtl/fp_divider_seq.sv
// fp_divider_seq: iterative radix-2 restoring IEEE-754 divider with valid/ready handshakes
module fp_divider_seq
  import fp_div_pkg::*;
#(
  parameter int BITS = 32,
  parameter int MANTISSA_BITS = 23,
  parameter int EXPONENT_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] x,
  input  logic [BITS-1:0] y,
  input  logic [1:0]      rnd_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out,
  output fp_flags_t       flags
);
  localparam int M = MANTISSA_BITS;
  localparam int E = EXPONENT_BITS;
  localparam int Q = M + 3;
  localparam int EW = E + 2;
  localparam int CW = $clog2(Q + 1);
  localparam int LW = $clog2(M + 2);
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam logic [BITS-1:0] QNAN = BITS'(fp_const(M, E, 1'b1));
  state_t state;
  rnd_mode_t rnd;
  logic [BITS-1:0] x_r, y_r, round_out, spec_out;
  logic [E-1:0] xe, ye;
  logic [M:0] div, mx, my, mxn, myn;
  logic [M+1:0] rem, diff;
  logic [Q-1:0] quot;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lzx, lzy;
  logic signed [EW-1:0] exp_r, ex, ey, e_prep;
  logic sign_xy, lt, ge, accept, special, nan_case, inf_case;
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  fp_flags_t round_flags, spec_flags;
  assign xe = x_r[BITS-2:M];
  assign ye = y_r[BITS-2:M];
  assign mx = {|xe, x_r[M-1:0]};
  assign my = {|ye, y_r[M-1:0]};
  assign x_nan = &xe && |x_r[M-1:0];
  assign y_nan = &ye && |y_r[M-1:0];
  assign x_inf = &xe && !(|x_r[M-1:0]);
  assign y_inf = &ye && !(|y_r[M-1:0]);
  assign x_zero = !(|x_r[BITS-2:0]);
  assign y_zero = !(|y_r[BITS-2:0]);
  assign sign_xy = x_r[BITS-1] ^ y_r[BITS-1];
  zeroMSBCounter #(.W(M + 1)) u_lzx (.value(mx), .count(lzx));
  zeroMSBCounter #(.W(M + 1)) u_lzy (.value(my), .count(lzy));
  assign mxn = mx << lzx;
  assign myn = my << lzy;
  assign ex = $signed({2'b00, xe == '0 ? E'(1) : xe}) - $signed(EW'(lzx));
  assign ey = $signed({2'b00, ye == '0 ? E'(1) : ye}) - $signed(EW'(lzy));
  assign lt = mxn < myn;
  assign e_prep = ex - ey + $signed(EW'(BIAS)) - $signed(EW'(lt));
  assign nan_case = x_nan | y_nan | (x_inf & y_inf) | (x_zero & y_zero);
  assign inf_case = x_inf | y_zero;
  assign special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;
  assign spec_out = nan_case ? QNAN : inf_case ? {sign_xy, {E{1'b1}}, {M{1'b0}}} : {sign_xy, {(BITS-1){1'b0}}};
  assign spec_flags = '{invalid: nan_case, div_by_zero: !nan_case && !x_inf && y_zero,
                        overflow: 1'b0, underflow: 1'b0, inexact: 1'b0};
  assign diff = rem - {1'b0, div};
  assign ge = rem >= {1'b0, div};
  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  fp_div_round #(.BITS(BITS), .MANTISSA_BITS(M), .EXPONENT_BITS(E)) u_round (
    .quot(quot), .sticky_in(|rem), .exp_in(exp_r), .sign(sign_xy), .rnd_mode(rnd),
    .result(round_out), .flags(round_flags)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd <= RNE;
      x_r <= '0;
      y_r <= '0;
      div <= '0;
      rem <= '0;
      quot <= '0;
      cnt <= '0;
      exp_r <= '0;
      out <= '0;
      flags <= '0;
    end else begin
      if (accept) begin
        x_r <= x;
        y_r <= y;
        rnd <= rnd_mode_t'(rnd_mode);
      end
      case (state)
        IDLE: state <= accept ? PREP : IDLE;
        PREP: begin
          state <= special ? DONE : DIVIDE;
          if (special) begin
            out <= spec_out;
            flags <= spec_flags;
          end
          rem <= lt ? {mxn, 1'b0} : {1'b0, mxn};
          div <= myn;
          exp_r <= e_prep;
          cnt <= '0;
          quot <= '0;
        end
        DIVIDE: begin
          quot <= {quot[Q-2:0], ge};
          rem <= (ge ? diff : rem) << 1;
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(Q - 1) ? ROUND : DIVIDE;
        end
        ROUND: begin
          out <= round_out;
          flags <= round_flags;
          state <= DONE;
        end
        DONE: state <= !out_ready ? DONE : accept ? PREP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_divider_seq.sv
// tb_fp_divider_seq: scoreboard bench with directed vectors for fp_divider_seq
module tb_fp_divider_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [31:0] x = 0, y = 0, out;
  logic [1:0] rnd_mode = 0;
  logic [4:0] flags;
  typedef struct {
    logic [31:0] o;
    logic [4:0] f;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, fails = 0, n;
  logic seen = 0, acc_in_done = 0;
  localparam int L = 29;
  localparam int S = 2;
  fp_divider_seq #(.BITS(32), .MANTISSA_BITS(23), .EXPONENT_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready), .out(out), .flags(flags)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input logic [31:0] eo, input logic [4:0] ef, input int lat, input bit push);
    int k = 0;
    x = a;
    y = b;
    rnd_mode = m;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no in_ready expected accept of %h/%h", a, b);
    end else begin
      acc_in_done = out_valid;
      if (push) sb.push_back('{o: eo, f: ef, lat: lat, acc: cyc});
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst) seen = 0;
    else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: got %h expected no result", out);
      end else begin
        if (!seen) check("latency", cyc - sb[0].acc, sb[0].lat);
        seen = 1;
        check("out", out, sb[0].o);
        check("flags", {27'd0, flags}, {27'd0, sb[0].f});
        if (!out_ready) check("in_ready_hold", {31'd0, in_ready}, 0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out", out, 0);
    check("rst_flags", {27'd0, flags}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    issue(32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, L, 1);
    issue(32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 5'b00001, L, 1);
    issue(32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00001, L, 1);
    issue(32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAB, 5'b00001, L, 1);
    issue(32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAAAA, 5'b00001, L, 1);
    issue(32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAB, 5'b00001, L, 1);
    issue(32'hBF800000, 32'h40400000, 2'd3, 32'hBEAAAAAA, 5'b00001, L, 1);
    issue(32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000, 5'b01000, S, 1);
    issue(32'h00000000, 32'h80000000, 2'd0, 32'h7FC00000, 5'b10000, S, 1);
    issue(32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b10000, S, 1);
    issue(32'h7F800000, 32'hFF800000, 2'd0, 32'h7FC00000, 5'b10000, S, 1);
    issue(32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 5'b00000, S, 1);
    issue(32'hBF800000, 32'h7F800000, 2'd0, 32'h80000000, 5'b00000, S, 1);
    issue(32'h7F7FFFFF, 32'h3F000000, 2'd0, 32'h7F800000, 5'b00101, L, 1);
    issue(32'h7F7FFFFF, 32'h3F000000, 2'd1, 32'h7F7FFFFF, 5'b00101, L, 1);
    issue(32'hFF7FFFFF, 32'h3F000000, 2'd2, 32'hFF800000, 5'b00101, L, 1);
    issue(32'hFF7FFFFF, 32'h3F000000, 2'd3, 32'hFF7FFFFF, 5'b00101, L, 1);
    issue(32'h00800000, 32'h40000000, 2'd0, 32'h00400000, 5'b00000, L, 1);
    issue(32'h00000003, 32'h40000000, 2'd0, 32'h00000002, 5'b00011, L, 1);
    check("b2b_accept_in_done", {31'd0, acc_in_done}, 1);
    drain();
    out_ready = 0;
    issue(32'h40C00000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000, L, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      fails++;
      $display("FAIL hold_wait: got out_valid=0 expected 1");
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1;
    drain();
    issue(32'h40C00000, 32'h40000000, 2'd0, 32'h0, 5'b0, L, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 0);
    check("abort_in_ready_in_rst", {31'd0, in_ready}, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("abort_in_ready_after", {31'd0, in_ready}, 1);
    check("abort_out_valid_after", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    issue(32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA, 5'b00001, L, 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
